// File: rtl/alu_job_scheduler.sv
// Shares one ALU between NUM_REQ requesters. A round-robin arbiter accepts one
// job at a time, issues it to the ALU, waits (under a watchdog) for completion and
// returns the tagged result on a single response channel.
//
// state  | meaning
// IDLE   | no job held; arbitrate and accept one pending request
// ISSUE  | pulse alu_begin for the captured job, clear watchdog
// WAIT   | ALU running; wait for alu_end or watchdog expiry
// RESP   | response presented until the consumer takes it
module alu_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic [3*NUM_REQ-1:0] i_req_op,
  input  logic [W*NUM_REQ-1:0] i_req_a,
  input  logic [W*NUM_REQ-1:0] i_req_b,
  output logic                 o_alu_begin,
  output logic [2:0]           o_alu_op,
  output logic [W-1:0]         o_alu_a,
  output logic [W-1:0]         o_alu_b,
  input  logic                 i_alu_end,
  input  logic [2*W-1:0]       i_alu_result,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [2*W-1:0]       o_rsp_result,
  output logic [1:0]           o_rsp_status,
  output logic                 o_busy
);

  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ID_W-1:0]    r_rrptr;
  logic [WD_W-1:0]    r_wdog;
  logic [2:0]         r_alu_op;
  logic [W-1:0]       r_alu_a;
  logic [W-1:0]       r_alu_b;
  logic [ID_W-1:0]    r_rsp_id;
  logic [2*W-1:0]     r_rsp_result;
  logic [1:0]         r_rsp_status;

  logic               w_grant_hit;
  logic [ID_W-1:0]    w_grant_id;
  logic [2:0]         w_grant_op;
  logic [W-1:0]       w_grant_a;
  logic [W-1:0]       w_grant_b;
  logic               w_illegal;
  logic               w_wdog_tc;

  // Round-robin search starting just after the last grant; the nearest hit wins
  // because the scan runs from the farthest candidate toward the nearest.
  always_comb begin
    logic [ID_W-1:0] w_scan_idx;
    w_grant_hit = 1'b0;
    w_grant_id  = '0;
    w_scan_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_scan_idx = ID_W'((int'(r_rrptr) + k) % NUM_REQ);
      if (i_req_valid[w_scan_idx]) begin
        w_grant_hit = 1'b1;
        w_grant_id  = w_scan_idx;
      end
    end
  end

  // Select the granted requester's op and operands.
  always_comb begin
    w_grant_op = '0;
    w_grant_a  = '0;
    w_grant_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_grant_op = i_req_op[3*i +: 3];
        w_grant_a  = i_req_a[W*i +: W];
        w_grant_b  = i_req_b[W*i +: W];
      end
    end
  end

  assign w_illegal = (w_grant_op == 3'b111);
  assign w_wdog_tc = (r_wdog == WD_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode; illegal ops skip the ALU and go straight to RESP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_hit) w_next = w_illegal ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (i_alu_end || w_wdog_tc) w_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake strobes decoded from the registered state; accept pulse also needs valid.
  always_comb begin
    o_req_ready = '0;
    o_alu_begin = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_grant_hit) o_req_ready = NUM_REQ'(1) << w_grant_id;
      S_ISSUE: o_alu_begin = 1'b1;
      S_RESP:  o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Job capture, watchdog and response registers; alu_end wins over the watchdog.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rrptr      <= ID_W'(NUM_REQ - 1);
      r_wdog       <= '0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_status <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_hit) begin
            r_alu_op <= w_grant_op;
            r_alu_a  <= w_grant_a;
            r_alu_b  <= w_grant_b;
            r_rsp_id <= w_grant_id;
            r_rrptr  <= w_grant_id;
            if (w_illegal) begin
              r_rsp_status <= ST_ILLEGAL;
              r_rsp_result <= '0;
            end
          end
        end
        S_ISSUE: r_wdog <= '0;
        S_WAIT: begin
          if (i_alu_end) begin
            r_rsp_result <= i_alu_result;
            r_rsp_status <= ST_OK;
          end else if (w_wdog_tc) begin
            r_rsp_result <= '0;
            r_rsp_status <= ST_TIMEOUT;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_alu_op     = r_alu_op;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_status = r_rsp_status;

endmodule

// File: tb/tb_alu_job_scheduler.sv
// Randomized and directed bench for alu_job_scheduler. A requester driver records
// the expected response of every accepted job into a scoreboard queue; an ALU
// model answers the DUT; an independent monitor pops and compares responses.
module tb_alu_job_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = 8;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    o_req_ready;
  logic [3*N-1:0]  i_req_op;
  logic [W*N-1:0]  i_req_a, i_req_b;
  logic            o_alu_begin;
  logic [2:0]      o_alu_op;
  logic [W-1:0]    o_alu_a, o_alu_b;
  logic            i_alu_end;
  logic [2*W-1:0]  i_alu_result;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [IW-1:0]   o_rsp_id;
  logic [2*W-1:0]  o_rsp_result;
  logic [1:0]      o_rsp_status;
  logic            o_busy;

  alu_job_scheduler #(.NUM_REQ(N), .ID_W(IW), .W(W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b),
    .o_alu_begin(o_alu_begin), .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .i_alu_end(i_alu_end), .i_alu_result(i_alu_result),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_id(o_rsp_id), .o_rsp_result(o_rsp_result), .o_rsp_status(o_rsp_status),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int id; logic [15:0] res; logic [1:0] st; int first; } exp_t;
  typedef struct { int d; int t; } alu_job_t;
  exp_t     sb_q[$];
  alu_job_t alu_q[$];
  int       grant_log[$];

  bit          job_v[N];
  logic [2:0]  job_op[N];
  logic [7:0]  job_a[N], job_b[N];
  int          job_d[N];   // WAIT cycle in which the ALU ends; 0 = never
  bit outstanding = 0, refill = 0, rnd = 0, stray_en = 0, alu_abort = 0;
  int last_grant = N - 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op == 3'b101) return 16'(a) * 16'(b);
    return {a ^ b, a + b} ^ {13'd0, op};
  endfunction

  function automatic int exp_grant(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_grant + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (job_v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_job(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int d);
    job_op[i] = op; job_a[i] = a; job_b[i] = b; job_d[i] = d; job_v[i] = 1'b1;
  endtask

  task automatic new_job(input int i, input bit legal_only);
    int r;
    r = $urandom_range(0, 15);
    job_op[i] = legal_only ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 7));
    job_a[i]  = 8'($urandom);
    job_b[i]  = 8'($urandom);
    job_d[i]  = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 25);
    job_v[i]  = 1'b1;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n = 0;
    while ((sb_q.size() != 0 || outstanding || any_pending()) && n < lim) begin
      tick();
      n++;
    end
    check(nm, 32'(n < lim), 32'd1);
  endtask

  // Requester driver: observe accepts mid-cycle, drive new request pins after the edge.
  initial begin : driver
    forever begin
      @(negedge clk);
      if (!i_reset && o_req_ready != '0) begin
        int eg, gi;
        exp_t e;
        logic [2:0] op;
        eg = exp_grant(i_req_valid);
        gi = -1;
        for (int i = 0; i < N; i++) if (o_req_ready[i]) gi = i;
        check("grant", 32'(o_req_ready), (eg < 0) ? 32'd0 : 32'(1 << eg));
        check("accept_while_outstanding", 32'(outstanding), 32'd0);
        grant_log.push_back(gi);
        if (eg >= 0) begin
          op    = i_req_op[3*eg +: 3];
          e.id  = eg;
          e.st  = (op == 3'b111) ? 2'b10 : (job_d[eg] == 0) ? 2'b01 : 2'b00;
          e.res = (e.st == 2'b00) ? alu_f(op, i_req_a[8*eg +: 8], i_req_b[8*eg +: 8]) : 16'd0;
          e.first = cyc + ((e.st == 2'b10) ? 1 : (e.st == 2'b01) ? 2 + TO : 2 + job_d[eg]);
          sb_q.push_back(e);
          if (e.st != 2'b10) alu_q.push_back('{job_d[eg], cyc});
          last_grant  = eg;
          outstanding = 1'b1;
          if (refill) new_job(eg, 1'b1);
          else        job_v[eg] = 1'b0;
        end
      end
      tick();
      if (rnd) begin
        for (int i = 0; i < N; i++) begin
          if (!job_v[i] && $urandom_range(0, 3) == 0) new_job(i, 1'b0);
          else if (job_v[i] && $urandom_range(0, 31) == 0) job_v[i] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        i_req_valid[i]      = job_v[i];
        i_req_op[3*i +: 3]  = job_op[i];
        i_req_a[8*i +: 8]   = job_a[i];
        i_req_b[8*i +: 8]   = job_b[i];
      end
    end
  end

  // ALU model: ends each job in its chosen WAIT cycle, optionally pulses stray alu_end when idle.
  initial begin : alu_model
    bit act = 0;
    int k = 0, d = 0;
    logic [2:0] cop = '0;
    logic [7:0] ca = '0, cb = '0;
    forever begin
      @(negedge clk);
      if (alu_abort) begin act = 0; alu_abort = 0; end
      if (act) begin
        check("alu_op_hold", 32'(o_alu_op), 32'(cop));
        check("alu_a_hold", 32'(o_alu_a), 32'(ca));
        check("alu_b_hold", 32'(o_alu_b), 32'(cb));
      end
      if (o_alu_begin) begin
        if (alu_q.size() == 0) check("unexpected_alu_begin", 32'(alu_q.size()), 32'd1);
        else begin
          alu_job_t j;
          j = alu_q.pop_front();
          check("alu_begin_latency", 32'(cyc), 32'(j.t + 1));
          act = 1; k = 0; d = j.d;
          cop = o_alu_op; ca = o_alu_a; cb = o_alu_b;
        end
      end
      tick();
      i_alu_end    = 1'b0;
      i_alu_result = 16'($urandom);
      if (act) begin
        k++;
        i_alu_result = alu_f(cop, ca, cb);
        if (d != 0 && k == d) i_alu_end = 1'b1;
        if (k == d || k == TO) act = 0;
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        i_alu_end = 1'b1;
      end
    end
  end

  // Response monitor: stability while stalled, then pop-and-compare on handshake.
  initial begin : monitor
    bit pv = 0;
    int first = 0;
    logic [IW-1:0]  pid = '0;
    logic [15:0]    pres = '0;
    logic [1:0]     pst = '0;
    forever begin
      @(negedge clk);
      if (o_rsp_valid) begin
        check("no_req_ready_in_resp", 32'(o_req_ready), 32'd0);
        check("no_alu_begin_in_resp", 32'(o_alu_begin), 32'd0);
        if (!pv) first = cyc;
        else begin
          check("rsp_id_stable", 32'(o_rsp_id), 32'(pid));
          check("rsp_result_stable", 32'(o_rsp_result), 32'(pres));
          check("rsp_status_stable", 32'(o_rsp_status), 32'(pst));
        end
        if (i_rsp_ready) begin
          if (sb_q.size() == 0) check("unexpected_rsp", 32'(sb_q.size()), 32'd1);
          else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rsp_id", 32'(o_rsp_id), 32'(e.id));
            check("rsp_result", 32'(o_rsp_result), 32'(e.res));
            check("rsp_status", 32'(o_rsp_status), 32'(e.st));
            check("rsp_latency", 32'(first), 32'(e.first));
            outstanding = 1'b0;
          end
          pv = 0;
        end else begin
          pv = 1; pid = o_rsp_id; pres = o_rsp_result; pst = o_rsp_status;
        end
      end else pv = 0;
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int n, gl0;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    i_reset = 1'b1; i_rsp_ready = 1'b0; i_alu_end = 1'b0; i_alu_result = '0;
    i_req_valid = '0; i_req_op = '0; i_req_a = '0; i_req_b = '0;
    for (int i = 0; i < N; i++) begin job_v[i] = 0; job_op[i] = 0; job_a[i] = 0; job_b[i] = 0; job_d[i] = 1; end
    repeat (3) tick();
    check("reset_busy", 32'(o_busy), 0);
    check("reset_rsp_valid", 32'(o_rsp_valid), 0);
    check("reset_alu_begin", 32'(o_alu_begin), 0);
    check("reset_req_ready", 32'(o_req_ready), 0);
    check("reset_alu_op", 32'(o_alu_op), 0);
    check("reset_alu_a", 32'(o_alu_a), 0);
    check("reset_rsp_result", 32'(o_rsp_result), 0);
    check("reset_rsp_status", 32'(o_rsp_status), 0);
    i_reset = 1'b0;
    i_rsp_ready = 1'b1;

    // All four continuously valid: round-robin order from reset.
    for (int i = 0; i < N; i++) new_job(i, 1'b1);
    refill = 1;
    n = 0;
    while (grant_log.size() < 6 && n < 1000) begin tick(); n++; end
    refill = 0;
    wait_idle(2000, "rr_drain");
    for (int i = 0; i < 6; i++) check("rr_order", 32'(grant_log[i]), 32'(order[i]));

    // Single multiply job on requester 0.
    set_job(0, 3'b101, 8'd12, 8'd10, 20);
    wait_idle(200, "single_job");

    // Consumer stalls for 10 cycles while another request is pending.
    set_job(1, 3'b010, 8'h5a, 8'h33, 3);
    n = 0;
    while (!o_rsp_valid && n < 100) begin tick(); n++; end
    check("stall_rsp_seen", 32'(o_rsp_valid), 32'd1);
    i_rsp_ready = 1'b0;
    set_job(2, 3'b001, 8'h11, 8'h22, 2);
    repeat (10) tick();
    i_rsp_ready = 1'b1;
    wait_idle(200, "stall_drain");

    // Illegal op bypasses the ALU.
    set_job(2, 3'b111, 8'hff, 8'h01, 5);
    wait_idle(50, "illegal_op");

    // Watchdog expiry, recovery, and alu_end on the last permitted cycle.
    set_job(3, 3'b001, 8'h40, 8'h02, 0);
    wait_idle(200, "timeout_job");
    set_job(0, 3'b011, 8'h07, 8'h09, 5);
    wait_idle(200, "after_timeout");
    set_job(1, 3'b100, 8'h81, 8'h18, TO);
    wait_idle(200, "end_on_last_cycle");

    // Reset during WAIT drops the job.
    set_job(2, 3'b011, 8'h3c, 8'hc3, 0);
    n = 0;
    while (!o_alu_begin && n < 50) begin tick(); n++; end
    check("reset_job_begin_seen", 32'(o_alu_begin), 32'd1);
    repeat (3) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    alu_abort = 1; sb_q.delete(); outstanding = 0; last_grant = N - 1;
    check("midrst_busy", 32'(o_busy), 0);
    check("midrst_rsp_valid", 32'(o_rsp_valid), 0);
    check("midrst_alu_begin", 32'(o_alu_begin), 0);
    check("midrst_alu_op", 32'(o_alu_op), 0);
    check("midrst_alu_b", 32'(o_alu_b), 0);
    check("midrst_rsp_id", 32'(o_rsp_id), 0);
    check("midrst_rsp_status", 32'(o_rsp_status), 0);
    repeat (5) tick();
    check("midrst_no_rsp", 32'(o_rsp_valid), 0);
    gl0 = grant_log.size();
    set_job(3, 3'b010, 8'h21, 8'h12, 4);
    set_job(0, 3'b101, 8'h03, 8'h05, 4);
    wait_idle(200, "after_reset_jobs");
    check("first_grant_after_reset", 32'(grant_log[gl0]), 32'd0);

    // Randomized traffic with drops, stray alu_end and consumer back-pressure.
    rnd = 1; stray_en = 1;
    repeat (3000) begin
      tick();
      i_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rnd = 0; stray_en = 0; i_rsp_ready = 1'b1;
    wait_idle(3000, "random_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
